// File: rtl/axiDemo_package.sv
// Shared AXI demo types: burst/response encodings, burst-generator status
// codes, burst-generator FSM states and the AXI 4KB page size.
package axiDemo_package;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axiBurstT;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axiRespT;

  typedef enum logic [1:0] {
    OK          = 2'b00,
    ID_MISMATCH = 2'b01,
    BOUNDARY    = 2'b10
  } burstGenStsT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_RESP,
    ST_REJ
  } gen_state_e;

  localparam int AXI_4KB = 4096;

endpackage

// File: rtl/axi_wr_burst_gen_beat.sv
// W-channel beat engine: beat counter, data pattern, wlast and the
// hold-while-stalled behaviour of the W payload.
module axi_wr_beat_gen #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8,
  parameter int PATTERN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic              wready_i,
  output logic              wvalid_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              wlast_o,
  output logic              last_hs_o,
  output logic              done_o
);

  logic [LEN_W-1:0] k_q, k_d;
  logic             wvalid_q, wvalid_d;
  logic             done_q, done_d;
  logic             beat_hs;

  // Payload is a pure function of registered state, so it cannot move while stalled.
  assign wvalid_o  = wvalid_q;
  assign wlast_o   = wvalid_q && (k_q == len_i);
  assign wdata_o   = (PATTERN == 1) ? seed_i : seed_i + DATA_W'(k_q);
  assign beat_hs   = wvalid_q && wready_i;
  assign last_hs_o = beat_hs && wlast_o;
  assign done_o    = done_q;

  // Next-state for the beat counter and W valid/done flags.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    k_d      = k_q;
    wvalid_d = wvalid_q;
    done_d   = done_q;
    if (start_i) begin
      k_d      = '0;
      wvalid_d = 1'b1;
      done_d   = 1'b0;
    end else if (beat_hs) begin
      if (wlast_o) begin
        // The counter stops on the last beat, so len = 2^LEN_W-1 never wraps early.
        wvalid_d = 1'b0;
        done_d   = 1'b1;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  // Beat-engine state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      k_q      <= '0;
      wvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      k_q      <= k_d;
      wvalid_q <= wvalid_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: rtl/axi_wr_burst_gen.sv
// AXI write-burst generator: accepts one command, screens it against the 4KB
// page rule, drives AW and W concurrently and reports the B response.
module axi_wr_burst_gen
  import axiDemo_package::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int LEN_W   = 8,
  parameter int PATTERN = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic [DATA_W-1:0]   cmd_seed,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [ID_W-1:0]     awid,
  output logic [LEN_W-1:0]    awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic [ID_W-1:0]     bid,
  input  logic                bvalid,
  output logic                bready,
  output logic                sts_valid,
  output logic [1:0]          sts_resp,
  output logic [1:0]          sts_code,
  output logic [ID_W-1:0]     sts_id
);

  localparam int         STRB_W = DATA_W / 8;
  localparam logic [2:0] AWSIZE = 3'($clog2(STRB_W));
  localparam int         SPAN_W = LEN_W + $clog2(STRB_W) + 14;

  gen_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              aw_done_q, aw_done_d;
  logic              sts_valid_q, sts_valid_d;
  axiRespT           sts_resp_q, sts_resp_d;
  burstGenStsT       sts_code_q, sts_code_d;
  logic [ID_W-1:0]   sts_id_q, sts_id_d;
  logic              out_en_q;

  logic              start;
  logic              aw_hs;
  logic              w_last_hs;
  logic              w_done;
  logic [SPAN_W-1:0] span;
  logic              crosses_4kb;

  // Bytes touched from the page offset; anything past 4096 leaves the 4KB page.
  assign span        = SPAN_W'(cmd_addr[11:0]) + ((SPAN_W'(cmd_len) + SPAN_W'(1)) << AWSIZE);
  assign crosses_4kb = span > SPAN_W'(AXI_4KB);

  // out_en_q keeps cmd_ready low while reset is asserted.
  assign cmd_ready = (state_q == ST_IDLE) && out_en_q;
  assign awvalid   = (state_q == ST_XFER) && !aw_done_q;
  assign aw_hs     = awvalid && awready;
  assign awaddr    = addr_q;
  assign awid      = id_q;
  assign awlen     = len_q;
  assign awsize    = awvalid ? AWSIZE : 3'd0;
  assign awburst   = awvalid ? INCR : FIXED;
  assign wid       = id_q;
  assign wstrb     = wvalid ? '1 : '0;
  assign bready    = (state_q == ST_RESP);
  assign sts_valid = sts_valid_q;
  assign sts_resp  = sts_resp_q;
  assign sts_code  = sts_code_q;
  assign sts_id    = sts_id_q;

  axi_wr_beat_gen #(
    .DATA_W  (DATA_W),
    .LEN_W   (LEN_W),
    .PATTERN (PATTERN)
  ) u_beat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .len_i     (len_q),
    .seed_i    (seed_q),
    .wready_i  (wready),
    .wvalid_o  (wvalid),
    .wdata_o   (wdata),
    .wlast_o   (wlast),
    .last_hs_o (w_last_hs),
    .done_o    (w_done)
  );

  // FSM next-state, command latch, AW completion and status generation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    id_d        = id_q;
    seed_d      = seed_q;
    aw_done_d   = aw_done_q;
    sts_valid_d = 1'b0;
    sts_resp_d  = sts_resp_q;
    sts_code_d  = sts_code_q;
    sts_id_d    = sts_id_q;
    start       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = cmd_addr;
          len_d     = cmd_len;
          id_d      = cmd_id;
          seed_d    = cmd_seed;
          aw_done_d = 1'b0;
          if (crosses_4kb) begin
            state_d = ST_REJ;
          end else begin
            state_d = ST_XFER;
            start   = 1'b1;
          end
        end
      end
      ST_XFER: begin
        if (aw_hs) aw_done_d = 1'b1;
        // AW and the last W beat may complete in either order or together.
        if ((aw_done_q || aw_hs) && (w_done || w_last_hs)) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bvalid) begin
          sts_valid_d = 1'b1;
          sts_resp_d  = axiRespT'(bresp);
          sts_code_d  = (bid != id_q) ? ID_MISMATCH : OK;
          sts_id_d    = id_q;
          state_d     = ST_IDLE;
        end
      end
      ST_REJ: begin
        sts_valid_d = 1'b1;
        sts_resp_d  = SLVERR;
        sts_code_d  = BOUNDARY;
        sts_id_d    = id_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and status registers; reset abandons any burst without a status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      id_q        <= '0;
      seed_q      <= '0;
      aw_done_q   <= 1'b0;
      sts_valid_q <= 1'b0;
      sts_resp_q  <= OKAY;
      sts_code_q  <= OK;
      sts_id_q    <= '0;
      out_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      id_q        <= id_d;
      seed_q      <= seed_d;
      aw_done_q   <= aw_done_d;
      sts_valid_q <= sts_valid_d;
      sts_resp_q  <= sts_resp_d;
      sts_code_q  <= sts_code_d;
      sts_id_q    <= sts_id_d;
      out_en_q    <= 1'b1;
    end
  end

endmodule
